alu_seq_core: RTL and testbench



---
 rtl/alu_seq_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Sequential ALU core: start/busy/done handshake, {N,V,C,Z} flags, shift-add multiply
// and a DEPTH-entry newest-first result history.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     btnC,
  input  logic                     btnU,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     store,
  input  logic                     clear,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         y,
  output logic [3:0]               flags,
  output logic [WIDTH-1:0]         hist,
  output logic [$clog2(DEPTH):0]   hist_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_NEG  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  localparam logic [CW-1:0]    MUL_LAST  = CW'(WIDTH);
  localparam logic [AW:0]      HIST_FULL = (AW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] W_MIN     = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic               r_store;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_y;
  logic [3:0]         r_flags;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW:0]        r_hist_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_alu_y;
  logic               w_alu_c;
  logic               w_alu_v;
  logic [WIDTH-1:0]   w_res_y;
  logic               w_res_c;
  logic               w_res_v;
  logic [3:0]         w_res_flags;
  logic               w_mul_last;
  logic               w_finish;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [AW-1:0]      w_rd_ptr;

  always_comb begin
    w_sum   = {1'b0, r_a} + {1'b0, r_b};
    w_diff  = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
    w_alu_y = {WIDTH{1'b0}};
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_y = w_sum[WIDTH-1:0];
        w_alu_c = w_sum[WIDTH];
        w_alu_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_y = w_diff[WIDTH-1:0];
        w_alu_c = w_diff[WIDTH];
        w_alu_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SHL: begin
        w_alu_y = {r_a[WIDTH-2:0], 1'b0};
        w_alu_c = r_a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_y = {1'b0, r_a[WIDTH-1:1]};
        w_alu_c = r_a[0];
      end
      OP_AND:  w_alu_y = r_a & r_b;
      OP_OR:   w_alu_y = r_a | r_b;
      OP_XOR:  w_alu_y = r_a ^ r_b;
      OP_NAND: w_alu_y = ~(r_a & r_b);
      OP_NOR:  w_alu_y = ~(r_a | r_b);
      OP_XNOR: w_alu_y = ~(r_a ^ r_b);
      OP_NOT:  w_alu_y = ~r_a;
      OP_NEG: begin
        w_alu_y = ~r_a + {{(WIDTH - 1){1'b0}}, 1'b1};
        w_alu_v = (r_a == W_MIN);
      end
      default: w_alu_y = {WIDTH{1'b0}};
    endcase
  end

  // MUL results come from the accumulator; carry flags any product bit beyond the result width
  always_comb begin
    if (r_state == S_MUL) begin
      w_res_y = r_acc[WIDTH-1:0];
      w_res_c = |r_acc[2*WIDTH-1:WIDTH];
      w_res_v = 1'b0;
    end else begin
      w_res_y = w_alu_y;
      w_res_c = w_alu_c;
      w_res_v = w_alu_v;
    end
  end

  assign w_res_flags = {w_res_y[WIDTH-1], w_res_v, w_res_c, (w_res_y == {WIDTH{1'b0}})};
  assign w_mul_last  = (r_cnt == MUL_LAST);
  assign w_finish    = (r_state == S_EXEC) || ((r_state == S_MUL) && w_mul_last);
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge btnC or posedge btnU) begin
    if (btnU) begin
      r_state  <= S_IDLE;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_op     <= 4'h0;
      r_store  <= 1'b0;
      r_mcand  <= {(2 * WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {(2 * WIDTH){1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_y      <= {WIDTH{1'b0}};
      r_flags  <= 4'h0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_store  <= store;
            r_busy   <= 1'b1;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= {(2 * WIDTH){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_state  <= (op == OP_MUL) ? S_MUL : S_EXEC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_y     <= w_res_y;
          r_flags <= w_res_flags;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        // WIDTH shift-add iterations, then one more cycle to publish the product
        S_MUL: begin
          if (w_mul_last) begin
            r_y     <= w_res_y;
            r_flags <= w_res_flags;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + {{(CW - 1){1'b0}}, 1'b1};
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // clear takes priority over a history write landing on the same edge
  always_ff @(posedge btnC or posedge btnU) begin
    if (btnU) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_hist_cnt <= {(AW + 1){1'b0}};
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_hist_cnt <= {(AW + 1){1'b0}};
    end else if (w_finish && r_store) begin
      r_mem[r_wr_ptr] <= w_res_y;
      r_wr_ptr        <= r_wr_ptr + AW'(1);
      r_hist_cnt      <= (r_hist_cnt == HIST_FULL) ? r_hist_cnt
                                                   : r_hist_cnt + {{AW{1'b0}}, 1'b1};
    end else begin
      r_wr_ptr   <= r_wr_ptr;
      r_hist_cnt <= r_hist_cnt;
    end
  end

  assign w_rd_ptr = r_wr_ptr - AW'(1) - rd_idx;

  always_comb begin
    if ({1'b0, rd_idx} < r_hist_cnt) begin
      hist = r_mem[w_rd_ptr];
    end else begin
      hist = {WIDTH{1'b0}};
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign y        = r_y;
  assign flags    = r_flags;
  assign hist_cnt = r_hist_cnt;

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized and directed bench for alu_seq_core, checked against an arithmetic
// reference model and a newest-first history queue.
module tb_alu_seq_core;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       btnC;
  logic       btnU;
  logic       start;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       store;
  logic       clear;
  logic [1:0] rd_idx;
  logic       busy;
  logic       done;
  logic [7:0] y;
  logic [3:0] flags;
  logic [7:0] hist;
  logic [2:0] hist_cnt;

  int n_vec = 0;
  int n_err = 0;
  int hq[$];

  alu_seq_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .btnC(btnC), .btnU(btnU), .start(start), .op(op), .a(a), .b(b),
    .store(store), .clear(clear), .rd_idx(rd_idx), .busy(busy), .done(done),
    .y(y), .flags(flags), .hist(hist), .hist_cnt(hist_cnt)
  );

  initial btnC = 1'b0;
  always #5 btnC = ~btnC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {N,V,C,Z,y} computed with plain integer arithmetic.
  function automatic logic [11:0] ref_op(input logic [3:0] o, input int xa, input int xb);
    int r, sa, sb;
    logic c, v;
    logic [7:0] yy;
    sa = (xa >= 128) ? xa - 256 : xa;
    sb = (xb >= 128) ? xb - 256 : xb;
    c = 1'b0;
    v = 1'b0;
    case (o)
      4'h0: begin r = xa + xb; c = (r > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      4'h1: begin r = xa + (255 - xb) + 1; c = (r > 255); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      4'h2: begin r = xa * 2; c = (xa >= 128); end
      4'h3: begin r = xa / 2; c = (xa % 2 == 1); end
      4'h4: r = xa & xb;
      4'h5: r = xa | xb;
      4'h6: r = xa ^ xb;
      4'h7: r = 255 - (xa & xb);
      4'h8: r = 255 - (xa | xb);
      4'h9: r = 255 - (xa ^ xb);
      4'hA: r = 255 - xa;
      4'hB: begin r = 256 - xa; v = (xa == 128); end
      4'hC: begin r = xa * xb; c = (r > 255); end
      default: r = 0;
    endcase
    yy = r[7:0];
    return {yy[7], v, c, (yy == 8'h00), yy};
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input logic st, input logic clr, input logic ign);
    logic [11:0] exp;
    int lat;
    int n;
    exp = ref_op(o, int'(xa), int'(xb));
    lat = (o == 4'hC) ? WIDTH + 2 : 2;
    @(negedge btnC);
    op = o; a = xa; b = xb; store = st; start = 1'b1;
    @(negedge btnC);
    n = 1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    store = ~st;
    while (done !== 1'b1 && n < 40) begin
      chk("busy_high", busy, 1);
      clear = (clr && n == lat - 1);
      if (ign && n < lat - 1 && (n % 2) == 1) begin
        start = 1'b1;
        op = 4'h0;
      end else begin
        start = 1'b0;
      end
      @(negedge btnC);
      n++;
    end
    start = 1'b0;
    clear = 1'b0;
    chk("latency", n, lat);
    chk("done", done, 1);
    chk("busy_low", busy, 0);
    chk("y", y, exp[7:0]);
    chk("flags", flags, exp[11:8]);
    if (clr) hq.delete();
    else if (st) begin
      hq.push_front(int'(exp[7:0]));
      if (hq.size() > DEPTH) hq.delete(DEPTH);
    end
    chk("hist_cnt", hist_cnt, hq.size());
    op = 4'h0; a = 8'h01; b = 8'h01; start = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      rd_idx = 2'(k);
      #1;
      chk("hist", hist, (k < hq.size()) ? hq[k] : 0);
    end
    @(negedge btnC);
    start = 1'b0;
    chk("done_pulse_end", done, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("y_held", y, exp[7:0]);
  endtask

  initial begin
    int dcount;
    btnU = 1'b1; start = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00;
    store = 1'b0; clear = 1'b0; rd_idx = 2'd0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", flags, 0);
    chk("rst_hist_cnt", hist_cnt, 0);
    chk("rst_hist", hist, 0);
    @(negedge btnC);
    btnU = 1'b0;

    run_op(4'h0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("add_7f_01_flags", flags, 4'b1100);
    run_op(4'h1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
    chk("sub_eq_flags", flags, 4'b0011);
    run_op(4'h1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("sub_borrow_y", y, 8'hFF);
    run_op(4'hC, 8'h0F, 8'h13, 1'b0, 1'b0, 1'b1);
    chk("mul_y", y, 8'h1D);
    chk("mul_c", flags[1], 1);
    run_op(4'hB, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(4'hB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(4'h2, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(4'h3, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(4'hD, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
    run_op(4'hF, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    chk("reserved_z", flags, 4'b0001);

    for (int i = 1; i <= 5; i++) run_op(4'h0, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0);
    chk("hist_cnt_sat", hist_cnt, 3'd4);
    for (int k = 0; k < DEPTH; k++) begin
      rd_idx = 2'(k);
      #1;
      chk("hist_wrap", hist, 5 - k);
    end

    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    run_op(4'h0, 8'h22, 8'h11, 1'b1, 1'b1, 1'b0);
    chk("clear_wins_cnt", hist_cnt, 0);
    rd_idx = 2'd0;
    #1;
    chk("clear_wins_hist", hist, 0);
    chk("clear_keeps_y", y, 8'h33);

    @(negedge btnC);
    op = 4'hC; a = 8'h0F; b = 8'h13; store = 1'b1; start = 1'b1;
    @(negedge btnC);
    start = 1'b0;
    repeat (3) @(negedge btnC);
    #2 btnU = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_y", y, 0);
    chk("abort_flags", flags, 0);
    chk("abort_done", done, 0);
    chk("abort_hist_cnt", hist_cnt, 0);
    @(negedge btnC);
    btnU = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(negedge btnC);
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    chk("abort_hist_cnt_after", hist_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
